xnor_serial_cmp_sched: RTL and testbench

//   Shares one 1-bit XNOR cell (four 2-input NAND primitives) between two requesters.

---
 rtl/xnor_serial_cmp_sched.sv | 104 ++++++++++
 tb/tb_xnor_serial_cmp_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/xnor_serial_cmp_sched.sv
// Round-robin scheduler sharing one NAND-built XNOR cell between two requesters.
// Each grant runs a WIDTH-bit equality compare bit-serially, LSB first.
module xnor_serial_cmp_sched #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic [WIDTH-1:0] match
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic             eq_acc;
  logic             rr_last;

  // Shared cell: classic four-NAND XOR, output taken inverted.
  logic n_ab, n_a, n_b, cell_xor, cell_bit;
  assign n_ab     = ~(sa[0] & sb[0]);
  assign n_a      = ~(sa[0] & n_ab);
  assign n_b      = ~(sb[0] & n_ab);
  assign cell_xor = ~(n_a & n_b);
  assign cell_bit = ~cell_xor;

  logic any_req;
  logic win1;
  logic last_bit;

  always_comb begin
    any_req  = req0 | req1;
    win1     = req1 & (~req0 | ~rr_last);
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      eq      <= 1'b0;
      match   <= '0;
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      eq_acc  <= 1'b0;
      rr_last <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant   <= win1 ? 2'b10 : 2'b01;
            rr_last <= win1;
            sa      <= win1 ? a1 : a0;
            sb      <= win1 ? b1 : b0;
            cnt     <= '0;
            eq_acc  <= 1'b1;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          match  <= {cell_bit, match[WIDTH-1:1]};
          eq_acc <= eq_acc & cell_bit;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            eq    <= eq_acc & cell_bit;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_serial_cmp_sched.sv
// Directed bench for xnor_serial_cmp_sched (WIDTH=8); all inputs driven and outputs sampled on negedge.
module tb_xnor_serial_cmp_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] grant;
  logic       busy, done, eq;
  logic [7:0] match;

  int n_checks = 0;
  int n_err    = 0;

  xnor_serial_cmp_sched #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .a0    (a0),
    .b0    (b0),
    .req1  (req1),
    .a1    (a1),
    .b1    (b1),
    .grant (grant),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .match (match)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advances at least one cycle, then until done is seen (bounded); n = negedges waited.
  task automatic wait_done(output logic [1:0] g, output logic e, output logic [7:0] m,
                           output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    check("done_seen", {31'd0, done}, 32'd1);
    g = grant;
    e = eq;
    m = match;
  endtask

  logic [1:0] g;
  logic       e;
  logic [7:0] m;
  int         n;
  int         done_hits;

  initial begin
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    a0 = 8'h12; b0 = 8'h12; a1 = 8'h34; b1 = 8'h35;

    // T1: reset holds everything low even with requests active
    repeat (3) @(negedge clk);
    check("t1_grant", {30'd0, grant}, 32'h0);
    check("t1_busy",  {31'd0, busy},  32'h0);
    check("t1_done",  {31'd0, done},  32'h0);
    check("t1_eq",    {31'd0, eq},    32'h0);
    check("t1_match", {24'd0, match}, 32'h0);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T2: equal operands on requester 0
    req0 = 1'b1; a0 = 8'hA5; b0 = 8'hA5;
    @(negedge clk);
    check("t2_grant_e0", {30'd0, grant}, 32'h1);
    check("t2_busy_e0",  {31'd0, busy},  32'h1);
    check("t2_match_hold", {24'd0, match}, 32'h0);
    repeat (6) @(negedge clk);
    check("t2_done_early", {31'd0, done}, 32'h0);
    n = 0;
    wait_done(g, e, m, n);
    check("t2_latency", n, 32'd2);
    check("t2_grant", {30'd0, g}, 32'h1);
    check("t2_eq",    {31'd0, e}, 32'h1);
    check("t2_match", {24'd0, m}, 32'hFF);
    req0 = 1'b0;
    @(negedge clk);
    check("t2_done_pulse", {31'd0, done},  32'h0);
    check("t2_grant_off",  {30'd0, grant}, 32'h0);
    check("t2_busy_off",   {31'd0, busy},  32'h0);
    check("t2_eq_hold",    {31'd0, eq},    32'h1);
    check("t2_match_hold2", {24'd0, match}, 32'hFF);

    // T3: requester 1, operand changed mid-op is ignored
    req1 = 1'b1; a1 = 8'h0F; b1 = 8'h0E;
    @(negedge clk);
    check("t3_grant_e0", {30'd0, grant}, 32'h2);
    repeat (3) @(negedge clk);
    a1 = 8'h00;
    wait_done(g, e, m, n);
    check("t3_grant", {30'd0, g}, 32'h2);
    check("t3_eq",    {31'd0, e}, 32'h0);
    check("t3_match", {24'd0, m}, 32'hFE);
    req1 = 1'b0;
    @(negedge clk);
    check("t3_grant_off", {30'd0, grant}, 32'h0);

    // T4: both held after reset -> 01,10,01, done every 10 cycles
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a0 = 8'h33; b0 = 8'h33; a1 = 8'h55; b1 = 8'h54;
    req0 = 1'b1; req1 = 1'b1;
    wait_done(g, e, m, n);
    check("t4_lat0",   n, 32'd9);
    check("t4_grant0", {30'd0, g}, 32'h1);
    check("t4_eq0",    {31'd0, e}, 32'h1);
    wait_done(g, e, m, n);
    check("t4_lat1",   n, 32'd10);
    check("t4_grant1", {30'd0, g}, 32'h2);
    check("t4_match1", {24'd0, m}, 32'hFE);
    wait_done(g, e, m, n);
    check("t4_lat2",   n, 32'd10);
    check("t4_grant2", {30'd0, g}, 32'h1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);

    // T5: complement operands, then single MSB difference
    req0 = 1'b1; a0 = 8'h3C; b0 = 8'hC3;
    wait_done(g, e, m, n);
    check("t5a_eq",    {31'd0, e}, 32'h0);
    check("t5a_match", {24'd0, m}, 32'h00);
    req0 = 1'b0;
    @(negedge clk);
    req0 = 1'b1; a0 = 8'h80; b0 = 8'h00;
    wait_done(g, e, m, n);
    check("t5b_eq",    {31'd0, e}, 32'h0);
    check("t5b_match", {24'd0, m}, 32'h7F);
    req0 = 1'b0;
    repeat (2) @(negedge clk);

    // T6: reset in the middle of a requester-1 op
    req1 = 1'b1; a1 = 8'hAA; b1 = 8'hAA;
    repeat (4) @(negedge clk);
    check("t6_busy_mid", {31'd0, busy}, 32'h1);
    rst_n = 1'b0;
    req1 = 1'b0; req0 = 1'b1; a0 = 8'h11; b0 = 8'h11;
    #1;
    check("t6_grant_rst", {30'd0, grant}, 32'h0);
    check("t6_busy_rst",  {31'd0, busy},  32'h0);
    check("t6_eq_rst",    {31'd0, eq},    32'h0);
    check("t6_match_rst", {24'd0, match}, 32'h00);
    done_hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) done_hits++;
    end
    check("t6_no_done", done_hits, 32'd0);
    rst_n = 1'b1;
    wait_done(g, e, m, n);
    check("t6_lat",   n, 32'd9);
    check("t6_grant", {30'd0, g}, 32'h1);
    check("t6_eq",    {31'd0, e}, 32'h1);
    check("t6_match", {24'd0, m}, 32'hFF);
    req0 = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
